// File: rtl/sprite_line_scheduler_if.sv
// Control, attribute-table, sprite-ROM and line-RAM signals of sprite_line_scheduler.
// master = line controller / memories side, slave = the scheduler itself.
interface sprite_line_scheduler_if;
  logic        i_Line_Start;
  logic [7:0]  i_Line_Y;
  logic        i_Buf_Sel;
  logic        i_Attr_Wr;
  logic [2:0]  i_Attr_Idx;
  logic [1:0]  i_Attr_Field;
  logic [7:0]  i_Attr_Data;
  logic [5:0]  o_Rom_Sprite;
  logic [2:0]  o_Rom_Row;
  logic [2:0]  o_Rom_Col;
  logic [1:0]  i_Rom_Pixel;
  logic        o_Lr_Write;
  logic [10:0] o_Lr_Addr;
  logic [1:0]  o_Lr_Data;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Overrun;
  logic        o_Limit_Hit;

  modport master (
    output i_Line_Start, i_Line_Y, i_Buf_Sel,
    output i_Attr_Wr, i_Attr_Idx, i_Attr_Field, i_Attr_Data,
    output i_Rom_Pixel,
    input  o_Rom_Sprite, o_Rom_Row, o_Rom_Col,
    input  o_Lr_Write, o_Lr_Addr, o_Lr_Data,
    input  o_Busy, o_Done, o_Overrun, o_Limit_Hit
  );

  modport slave (
    input  i_Line_Start, i_Line_Y, i_Buf_Sel,
    input  i_Attr_Wr, i_Attr_Idx, i_Attr_Field, i_Attr_Data,
    input  i_Rom_Pixel,
    output o_Rom_Sprite, o_Rom_Row, o_Rom_Col,
    output o_Lr_Write, o_Lr_Addr, o_Lr_Data,
    output o_Busy, o_Done, o_Overrun, o_Limit_Hit
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Builds one 256-pixel sprite line into a ping-pong line RAM: clear, scan 8 sprites, fetch hits.
// Optional macro SPRITE_LINE_LIMIT_EN caps each line at 4 drawn sprites and flags o_Limit_Hit.
module sprite_line_scheduler (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  sprite_line_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_FETCH, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] clr_x_q, clr_x_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] col_q, col_d;
  logic [7:0] line_y_q, line_y_d;
  logic       buf_q, buf_d;
  logic [5:0] cur_num_q, cur_num_d;
  logic [7:0] cur_x_q, cur_x_d;
  logic [2:0] cur_row_q, cur_row_d;

  logic [5:0] attr_num [8];
  logic [7:0] attr_x   [8];
  logic [7:0] attr_y   [8];
  logic       attr_en  [8];

  logic [7:0] delta;
  logic       hit;
  logic       skip;
  logic       busy;
  logic       clear_wr;
  logic       fetch_wr;
  logic       lr_write;
  logic       rom_on;
  logic [2:0] col_m1;
  logic [7:0] wr_x;

  // NOTE: the attribute table is reset element by element because reset must leave every sprite disabled.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < 8; i++) begin
        attr_num[i] <= '0;
        attr_x[i]   <= '0;
        attr_y[i]   <= '0;
        attr_en[i]  <= 1'b0;
      end
    end else if (bus.i_Attr_Wr) begin
      case (bus.i_Attr_Field)
        2'd0:    attr_num[bus.i_Attr_Idx] <= bus.i_Attr_Data[5:0];
        2'd1:    attr_x[bus.i_Attr_Idx]   <= bus.i_Attr_Data;
        2'd2:    attr_y[bus.i_Attr_Idx]   <= bus.i_Attr_Data;
        default: attr_en[bus.i_Attr_Idx]  <= bus.i_Attr_Data[0];
      endcase
    end
  end

  // Table reads are combinational on the registered table, so a same-cycle write is not seen by SCAN.
  assign delta = line_y_q - attr_y[idx_q];
  assign hit   = attr_en[idx_q] && (delta < 8'd8);

`ifdef SPRITE_LINE_LIMIT_EN
  logic [2:0] drawn_q, drawn_d;
  logic       limit_q, limit_d;

  assign skip = (drawn_q == 3'd4);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      drawn_q <= '0;
      limit_q <= 1'b0;
    end else begin
      drawn_q <= drawn_d;
      limit_q <= limit_d;
    end
  end

  assign bus.o_Limit_Hit = limit_q;
`else
  assign skip            = 1'b0;
  assign bus.o_Limit_Hit = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      clr_x_q   <= '0;
      idx_q     <= '0;
      col_q     <= '0;
      line_y_q  <= '0;
      buf_q     <= 1'b0;
      cur_num_q <= '0;
      cur_x_q   <= '0;
      cur_row_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_x_q   <= clr_x_d;
      idx_q     <= idx_d;
      col_q     <= col_d;
      line_y_q  <= line_y_d;
      buf_q     <= buf_d;
      cur_num_q <= cur_num_d;
      cur_x_q   <= cur_x_d;
      cur_row_q <= cur_row_d;
    end
  end

  // NOTE: every next-state variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    clr_x_d   = clr_x_q;
    idx_d     = idx_q;
    col_d     = col_q;
    line_y_d  = line_y_q;
    buf_d     = buf_q;
    cur_num_d = cur_num_q;
    cur_x_d   = cur_x_q;
    cur_row_d = cur_row_q;
`ifdef SPRITE_LINE_LIMIT_EN
    drawn_d   = drawn_q;
    limit_d   = limit_q;
`endif
    // A start in any state (re)starts the line; when busy this is the overrun abort.
    if (bus.i_Line_Start) begin
      state_d  = S_CLEAR;
      clr_x_d  = '0;
      line_y_d = bus.i_Line_Y;
      buf_d    = bus.i_Buf_Sel;
`ifdef SPRITE_LINE_LIMIT_EN
      drawn_d  = '0;
      limit_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_x_d = clr_x_q + 8'd1;
          if (clr_x_q == 8'hff) begin
            state_d = S_SCAN;
            idx_d   = '0;
          end
        end
        S_SCAN: begin
          cur_num_d = attr_num[idx_q];
          cur_x_d   = attr_x[idx_q];
          cur_row_d = delta[2:0];
          if (hit && !skip) begin
            state_d = S_FETCH;
            col_d   = '0;
`ifdef SPRITE_LINE_LIMIT_EN
            drawn_d = drawn_q + 3'd1;
`endif
          end else begin
`ifdef SPRITE_LINE_LIMIT_EN
            if (hit) limit_d = 1'b1;
`endif
            if (idx_q == 3'd7) state_d = S_DONE;
            else               idx_d   = idx_q + 3'd1;
          end
        end
        S_FETCH: begin
          col_d = col_q + 4'd1;
          if (col_q == 4'd8) begin
            if (idx_q == 3'd7) begin
              state_d = S_DONE;
            end else begin
              state_d = S_SCAN;
              idx_d   = idx_q + 3'd1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Pixel for column c returns one cycle after its address, so it is written while col_q = c+1.
  assign busy     = (state_q != S_IDLE);
  assign clear_wr = (state_q == S_CLEAR);
  assign fetch_wr = (state_q == S_FETCH) && (col_q != 4'd0) && (bus.i_Rom_Pixel != 2'b00);
  assign lr_write = clear_wr || fetch_wr;
  assign col_m1   = col_q[2:0] - 3'd1;
  assign wr_x     = clear_wr ? clr_x_q : (cur_x_q + {5'd0, col_m1});
  assign rom_on   = (state_q == S_FETCH) && !col_q[3];

  assign bus.o_Lr_Write   = lr_write;
  assign bus.o_Lr_Addr    = lr_write ? {2'b00, buf_q, wr_x} : 11'd0;
  assign bus.o_Lr_Data    = fetch_wr ? bus.i_Rom_Pixel : 2'b00;
  assign bus.o_Rom_Sprite = rom_on ? cur_num_q : 6'd0;
  assign bus.o_Rom_Row    = rom_on ? cur_row_q : 3'd0;
  assign bus.o_Rom_Col    = rom_on ? col_q[2:0] : 3'd0;
  assign bus.o_Busy       = busy;
  assign bus.o_Done       = (state_q == S_DONE);
  assign bus.o_Overrun    = bus.i_Line_Start && busy;

endmodule
